fir_coeff_loader: RTL
=====================

# fir_coeff_loader

Upstream control stage for the reconfigurable FIR filter. It generates the 600 kHz sample-enable strobe from the 12 MHz clock. It accepts 11 signed coefficients over a valid/ready handshake and buffers them. It then replays them into the filter's coefficient RAM port with the required update-flag framing, aligned so the whole update fits between two sample strobes.

## Interface
Parameters:
- NUM_TAPS, 11, coefficients per update (RAM addresses 0..NUM_TAPS-1)
- COEFF_W, 9, input coefficient width (two's complement)
- DATA_W, 16, RAM write-data width
- ADDR_W, 6, RAM address width
- DIV, 20, clock cycles per sample strobe (12 MHz / 600 kHz)

Ports:
- iClk12M  in  1  system clock, 12 MHz; one clock; all state on rising edge
- iRsn  in  1  reset, asynchronous, active-low
- iCoeffValid  in  1  coefficient word valid
- iCoeff  in  COEFF_W  signed coefficient
- oCoeffReady  out  1  loader accepts a coefficient this cycle
- oEnSample600k  out  1  one-cycle sample strobe, period DIV
- oCoeffUpdateFlag  out  1  filter update-mode flag
- oCsnRam  out  1  RAM chip select, active-low
- oWrnRam  out  1  RAM write enable, active-low
- oAddrRam  out  ADDR_W  RAM address
- oWtDtRam  out  DATA_W  RAM write data
- oBusy  out  1  high from the first accepted coefficient until the update completes
- oDone  out  1  one-cycle pulse when an update completes

## Operation
- Sample strobe: counter cnt runs 0..DIV-1.
  - On the edge where cnt==DIV-1: cnt<=0 and oEnSample600k<=1.
  - Otherwise: cnt<=cnt+1 and oEnSample600k<=0.
  - The strobe runs continuously and is independent of the FSM.
- FSM states: COLLECT, ARM, SETUP, WRITE, HOLD, DONE.
- COLLECT:
  - oCoeffReady=1.
  - On iCoeffValid&&oCoeffReady: buf[idx]<=iCoeff and idx<=idx+1.
  - When the NUM_TAPS-th word is accepted, go to ARM with idx<=0.
- ARM:
  - oCoeffReady=0.
  - Wait until oEnSample600k==1, then go to SETUP next edge.
- SETUP: oCoeffUpdateFlag=1, RAM idle, 1 cycle, then WRITE.
- WRITE: NUM_TAPS cycles. In cycle k:
  - oCsnRam=0 and oWrnRam=0.
  - oAddrRam=k.
  - oWtDtRam=sign-extend(buf[k]) to DATA_W.
- HOLD:
  - oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0.
  - oCoeffUpdateFlag stays 1 for 2 cycles.
- DONE:
  - oCoeffUpdateFlag=0, oDone=1, for 1 cycle.
  - Then COLLECT with buffer index 0.
- Arithmetic: sign extension replicates bit COEFF_W-1. Example: 9'h1F3 -> 16'hFFF3; 9'h0CD -> 16'h00CD. No saturation.
- oBusy rises the cycle after the first accepted word and falls together with the oDone pulse.

## Timing
- Reset values: all are registered outputs.
  - oEnSample600k=0, oCoeffUpdateFlag=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oBusy=0, oDone=0.
  - oCoeffReady=1.
  - cnt=0, idx=0, state COLLECT, buffer cleared to 0.
- First strobe occurs DIV rising edges after reset release; strobes are then exactly DIV cycles apart.
- The SETUP edge is the strobe cycle's edge. The update spans 1+NUM_TAPS+2 = 14 cycles, always finishing before the next strobe (requires DIV >= NUM_TAPS+4, checked by elaboration assertion).
- If the last coefficient is accepted in the same cycle oEnSample600k is high, ARM waits for the following strobe. No partial window is used.
- iCoeffValid while oCoeffReady=0 is ignored; no word is consumed.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The buffer is discarded, the RAM port is deasserted immediately and the flag drops. The sample counter restarts.
- Latency: last coefficient accepted -> first RAM write is 2 to DIV+1 cycles, depending on strobe phase.

## Structure
- Shared package fir_pkg:
  - NUM_TAPS, DIV, COEFF_W, DATA_W, ADDR_W constants.
  - Loader state encoding (COLLECT..DONE) as localparams.
  - A sign-extension function.
- Sub-module sample_en_gen: the DIV counter and strobe register, parameterised by DIV. The loader instantiates it and taps its strobe internally.
- Coefficient buffer: NUM_TAPS x COEFF_W register array, not RAM.

## Test plan
- Reset release, no stimulus -> oEnSample600k pulses at cycles 20, 40, 60 after release, each 1 cycle wide. RAM outputs stay at idle values (oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0).
- Stream 11 words 9'h00C,0,9'h013,9'h017,0,9'h024,9'h030,0,9'h065,9'h0CD,9'h1F3 back-to-back, then check from the next strobe:
  - 1 flag-only cycle.
  - 11 writes, addr 0..10, data 16'h000C..16'h00CD, 16'hFFF3.
  - 2 flag-hold cycles, then oDone pulse, then oCoeffReady=1.
- Gapped valid: toggle iCoeffValid every other cycle. Drive iCoeffValid high during ARM/WRITE -> only 11 words are consumed and extra words are not written. oCoeffReady=0 from the 11th accept until DONE.
- Last word accepted in the strobe cycle -> SETUP is delayed exactly DIV cycles. No RAM activity occurs before the next strobe.
- Pull iRsn low during WRITE at address 5 -> same-cycle oCsnRam=1, oWrnRam=1, oCoeffUpdateFlag=0, oBusy=0. After release, a fresh 11-word load writes all addresses correctly.
- Back-to-back updates: the second load starts immediately after oDone -> each update is confined to a single inter-strobe window. oCoeffUpdateFlag is low for at least 1 cycle between the two updates.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants, loader state encoding and arithmetic helpers for the
// reconfigurable FIR filter's coefficient-loading front end.
//   FIR_NUM_TAPS  coefficients per update (RAM addresses 0..FIR_NUM_TAPS-1)
//   FIR_COEFF_W   incoming coefficient width, two's complement
//   FIR_DATA_W    coefficient RAM write-data width
//   FIR_ADDR_W    coefficient RAM address width
//   FIR_DIV       12 MHz clock cycles per 600 kHz sample strobe
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int unsigned FIR_NUM_TAPS = 11;
    localparam int unsigned FIR_COEFF_W  = 9;
    localparam int unsigned FIR_DATA_W   = 16;
    localparam int unsigned FIR_ADDR_W   = 6;
    localparam int unsigned FIR_DIV      = 20;

    // Cycles the update flag is held after the last RAM write.
    localparam int unsigned FIR_HOLD_CYCLES = 2;

    // Loader state encoding.
    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        StCollect = ST_COLLECT,
        StArm     = ST_ARM,
        StSetup   = ST_SETUP,
        StWrite   = ST_WRITE,
        StHold    = ST_HOLD,
        StDone    = ST_DONE
    } loaderState_t;

    // Replicate the coefficient sign bit up to the RAM data width; no saturation.
    function automatic logic [FIR_DATA_W-1:0] signExtend(input logic [FIR_COEFF_W-1:0] coeff);
        return {{(FIR_DATA_W - FIR_COEFF_W){coeff[FIR_COEFF_W-1]}}, coeff};
    endfunction

endpackage

// File: rtl/sample_en_gen.sv
// -----------------------------------------------------------------------------
// sample_en_gen
// Free-running divider producing a one-cycle enable every DIV clock cycles.
// The first strobe appears DIV rising edges after reset release.
// Ports:
//   iClk12M    system clock
//   iRsn       asynchronous active-low reset
//   oEnSample  registered one-cycle strobe, period DIV
// -----------------------------------------------------------------------------
module sample_en_gen #(
    parameter int unsigned DIV = 20
) (
    input  logic iClk12M,
    input  logic iRsn,
    output logic oEnSample
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cntQ;

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            cntQ      <= '0;
            oEnSample <= 1'b0;
        end else if (cntQ == CNT_MAX) begin
            cntQ      <= '0;
            oEnSample <= 1'b1;
        end else begin
            cntQ      <= cntQ + 1'b1;
            oEnSample <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Collects NUM_TAPS signed coefficients over a valid/ready handshake into a
// register buffer, then replays them into the filter's coefficient RAM port
// framed by the update flag. The replay starts on a sample strobe so that the
// whole update (flag setup, NUM_TAPS writes, flag hold, done) completes before
// the following strobe.
// Ports:
//   iClk12M           12 MHz system clock
//   iRsn              asynchronous active-low reset
//   iCoeffValid       coefficient word valid
//   iCoeff            signed coefficient word
//   oCoeffReady       loader accepts a word this cycle
//   oEnSample600k     one-cycle sample strobe, period DIV
//   oCoeffUpdateFlag  filter update-mode flag
//   oCsnRam           RAM chip select, active-low
//   oWrnRam           RAM write enable, active-low
//   oAddrRam          RAM address
//   oWtDtRam          RAM write data (sign-extended coefficient)
//   oBusy             high from the first accepted word until the update completes
//   oDone             one-cycle pulse when an update completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAPS = FIR_NUM_TAPS,
    parameter int unsigned COEFF_W  = FIR_COEFF_W,
    parameter int unsigned DATA_W   = FIR_DATA_W,
    parameter int unsigned ADDR_W   = FIR_ADDR_W,
    parameter int unsigned DIV      = FIR_DIV
) (
    input  logic               iClk12M,
    input  logic               iRsn,
    input  logic               iCoeffValid,
    input  logic [COEFF_W-1:0] iCoeff,
    output logic               oCoeffReady,
    output logic               oEnSample600k,
    output logic               oCoeffUpdateFlag,
    output logic               oCsnRam,
    output logic               oWrnRam,
    output logic [ADDR_W-1:0]  oAddrRam,
    output logic [DATA_W-1:0]  oWtDtRam,
    output logic               oBusy,
    output logic               oDone
);

    // The update must fit between two strobes and every tap needs an address.
    if (DIV < NUM_TAPS + 4) begin : gDivCheck
        $error("DIV must be at least NUM_TAPS+4 so an update fits between strobes");
    end
    if (NUM_TAPS > (1 << ADDR_W)) begin : gAddrCheck
        $error("ADDR_W too narrow for NUM_TAPS");
    end

    localparam int unsigned     IDX_W     = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] LAST_HOLD = IDX_W'(FIR_HOLD_CYCLES - 1);

    logic enSample;

    sample_en_gen #(
        .DIV(DIV)
    ) uSampleEnGen (
        .iClk12M  (iClk12M),
        .iRsn     (iRsn),
        .oEnSample(enSample)
    );

    assign oEnSample600k = enSample;

    loaderState_t       stateQ, stateD;
    // Shared index: buffer slot while collecting, write slot while writing,
    // hold-cycle count while holding.
    logic [IDX_W-1:0]   idxQ, idxD;
    logic [COEFF_W-1:0] coeffBuf [NUM_TAPS];
    logic               accept;

    logic               readyD;
    logic               flagD;
    logic               csnD;
    logic               wrnD;
    logic [ADDR_W-1:0]  addrD;
    logic [DATA_W-1:0]  dataD;
    logic               busyD;
    logic               doneD;

    // oCoeffReady is high exactly while collecting, so it doubles as the accept gate.
    assign accept = iCoeffValid & oCoeffReady;

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        unique case (stateQ)
            StCollect: begin
                if (accept) begin
                    if (idxQ == LAST_IDX) begin
                        stateD = StArm;
                        idxD   = '0;
                    end else begin
                        idxD = idxQ + 1'b1;
                    end
                end
            end
            StArm: begin
                // A strobe seen here means the next edge opens a fresh window.
                if (enSample) begin
                    stateD = StSetup;
                end
            end
            StSetup: begin
                stateD = StWrite;
                idxD   = '0;
            end
            StWrite: begin
                if (idxQ == LAST_IDX) begin
                    stateD = StHold;
                    idxD   = '0;
                end else begin
                    idxD = idxQ + 1'b1;
                end
            end
            StHold: begin
                if (idxQ == LAST_HOLD) begin
                    stateD = StDone;
                    idxD   = '0;
                end else begin
                    idxD = idxQ + 1'b1;
                end
            end
            StDone: begin
                stateD = StCollect;
                idxD   = '0;
            end
            default: begin
                stateD = StCollect;
                idxD   = '0;
            end
        endcase
    end

    // Output values are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        readyD = (stateD == StCollect);
        flagD  = (stateD == StSetup) || (stateD == StWrite) || (stateD == StHold);
        csnD   = 1'b1;
        wrnD   = 1'b1;
        addrD  = '0;
        dataD  = '0;
        doneD  = (stateD == StDone);
        busyD  = (stateD == StCollect) ? (idxD != '0) : (stateD != StDone);
        if (stateD == StWrite) begin
            csnD  = 1'b0;
            wrnD  = 1'b0;
            addrD = ADDR_W'(idxD);
            dataD = signExtend(coeffBuf[idxD]);
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            stateQ           <= StCollect;
            idxQ             <= '0;
            oCoeffReady      <= 1'b1;
            oCoeffUpdateFlag <= 1'b0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oAddrRam         <= '0;
            oWtDtRam         <= '0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
        end else begin
            stateQ           <= stateD;
            idxQ             <= idxD;
            oCoeffReady      <= readyD;
            oCoeffUpdateFlag <= flagD;
            oCsnRam          <= csnD;
            oWrnRam          <= wrnD;
            oAddrRam         <= addrD;
            oWtDtRam         <= dataD;
            oBusy            <= busyD;
            oDone            <= doneD;
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                coeffBuf[i] <= '0;
            end
        end else if (accept) begin
            coeffBuf[idxQ] <= iCoeff;
        end
    end

endmodule
